// File: rtl/cpu_pkg.sv
// Shared pipeline control definitions: control-bit positions, hazard FSM states,
// forwarding select encodings.
package cpu_pkg;

  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    HZ_INIT     = 2'd0,
    HZ_RUN      = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_ERROR    = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Register 0 is hardwired to zero when r0_zero is set, so it never matches.
  function automatic logic reg_match(input logic [2:0] a, input logic [2:0] b,
                                     input bit r0_zero);
    return (a == b) && !(r0_zero && (a == 3'd0));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX operand forwarding selects; EX/MEM result beats MEM/WB, loads in EX/MEM
// are not yet available and so never forward from that stage.
module pipe_fwd_unit
  import cpu_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic     mem_reg_write,
  input  logic     mem_read,
  input  logic [2:0] mem_rd,
  input  logic     wb_reg_write,
  input  logic [2:0] wb_rd,
  input  logic [2:0] ex_rs1,
  input  logic [2:0] ex_rs2,
  output fwd_sel_t fwd_a,
  output fwd_sel_t fwd_b
);

  logic mem_fwd_ok;
  assign mem_fwd_ok = mem_reg_write && !mem_read;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_fwd_ok && reg_match(mem_rd, ex_rs1, R0_ZERO)) fwd_a = FWD_MEM;
    else if (wb_reg_write && reg_match(wb_rd, ex_rs1, R0_ZERO)) fwd_a = FWD_WB;
    if (mem_fwd_ok && reg_match(mem_rd, ex_rs2, R0_ZERO)) fwd_b = FWD_MEM;
    else if (wb_reg_write && reg_match(wb_rd, ex_rs2, R0_ZERO)) fwd_b = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: post-reset scrub, load-use stall, branch flush,
// data-memory wait freeze with timeout watchdog, and forwarding selects.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          R0_ZERO     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic [3:0]  ex_ctrl,
  input  logic [2:0]  ex_rd,
  input  logic [2:0]  ex_rs1,
  input  logic [2:0]  ex_rs2,
  input  logic        ex_branch_taken,
  input  logic [3:0]  mem_ctrl,
  input  logic [2:0]  mem_rd,
  input  logic [3:0]  wb_ctrl,
  input  logic [2:0]  wb_rd,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        dmem_req,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        ctrl_err,
  output logic [15:0] stall_cycles
);

  hz_state_t   state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ctrl_err_q, ctrl_err_d;
  logic [15:0] stall_q, stall_d;

  logic memacc, load_use;
  fwd_sel_t fwd_a_sel, fwd_b_sel;

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{ex_ctrl[3], ex_ctrl[1:0], mem_ctrl[CTRL_MEM_TO_REG], wb_ctrl[2:0]};

  assign memacc   = mem_ctrl[CTRL_MEM_READ] | mem_ctrl[CTRL_MEM_WRITE];
  assign load_use = ex_ctrl[CTRL_MEM_READ] &&
                    (reg_match(ex_rd, id_rs1, R0_ZERO) || reg_match(ex_rd, id_rs2, R0_ZERO));

  pipe_fwd_unit #(.R0_ZERO(R0_ZERO)) u_fwd (
    .mem_reg_write (mem_ctrl[CTRL_REG_WRITE]),
    .mem_read      (mem_ctrl[CTRL_MEM_READ]),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_ctrl[CTRL_REG_WRITE]),
    .wb_rd         (wb_rd),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .fwd_a         (fwd_a_sel),
    .fwd_b         (fwd_b_sel)
  );

  assign fwd_a        = fwd_a_sel;
  assign fwd_b        = fwd_b_sel;
  assign ctrl_err     = ctrl_err_q;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HZ_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      ctrl_err_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_err_q <= ctrl_err_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    ctrl_err_d   = ctrl_err_q;
    stall_d      = stall_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = 1'b0;

    unique case (state_q)
      HZ_INIT: begin
        {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = '1;
        if (init_cnt_q == 16'(INIT_CYCLES - 1)) state_d = HZ_RUN;
        else init_cnt_d = init_cnt_q + 16'd1;
      end
      HZ_RUN: begin
        dmem_req = memacc;
        if (memacc && !dmem_ready) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
          mem_wb_flush = 1'b1;
          state_d      = HZ_MEM_WAIT;
          wait_cnt_d   = 8'd1;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = HZ_RUN;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
          mem_wb_flush = 1'b1;
          if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
            state_d    = HZ_ERROR;
            ctrl_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      HZ_ERROR: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      end
      default: state_d = HZ_INIT;
    endcase

    if ((state_q == HZ_RUN || state_q == HZ_MEM_WAIT) && !pc_en && (stall_q != '1))
      stall_d = stall_q + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes expected outputs into a scoreboard,
// an independent monitor compares them on the falling edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic [3:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_branch_taken, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        dmem_req, ctrl_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  typedef struct {
    string       name;
    logic [29:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.INIT_CYCLES(3), .MEM_TIMEOUT(15), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_branch_taken(ex_branch_taken),
    .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .dmem_req(dmem_req), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ctrl_err(ctrl_err), .stall_cycles(stall_cycles)
  );

  // Packing: {en[pc,ifid,idex,exmem], flush[ifid,idex,exmem,memwb], req, fa, fb, err, stall}
  always @(negedge clk) begin
    sb_t         e;
    logic [29:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             dmem_req, fwd_a, fwd_b, ctrl_err, stall_cycles};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s @%0t: got en=%b fl=%b req=%b fa=%b fb=%b err=%b stall=%0d, expected en=%b fl=%b req=%b fa=%b fb=%b err=%b stall=%0d",
                 e.name, $time, act[29:26], act[25:22], act[21], act[20:19], act[18:17],
                 act[16], act[15:0], e.v[29:26], e.v[25:22], e.v[21], e.v[20:19],
                 e.v[18:17], e.v[16], e.v[15:0]);
      end
    end
  end

  task automatic push_exp(input string n, input logic [3:0] en, input logic [3:0] fl,
                          input logic req, input logic [1:0] fa, input logic [1:0] fb,
                          input logic err, input logic [15:0] st);
    sb_t e;
    e.name = n;
    e.v    = {en, fl, req, fa, fb, err, st};
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    id_rs1 = '0; id_rs2 = '0; ex_ctrl = '0; ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_branch_taken = 1'b0; mem_ctrl = '0; mem_rd = '0; wb_ctrl = '0; wb_rd = '0;
    dmem_ready = 1'b0;
  endtask

  task automatic reset_and_init;
    rst_n = 1'b0;
    push_exp("reset", 4'hF, 4'hF, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp("init_scrub", 4'hF, 4'hF, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
      step;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    step;
    reset_and_init();

    push_exp("run_idle", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;

    ex_ctrl = 4'b1100; ex_rd = 3'd2; id_rs2 = 3'd2;
    push_exp("load_use", 4'b0011, 4'b0100, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;
    clr();
    push_exp("after_load_use", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd1);
    step;

    ex_ctrl = 4'b1100; ex_rd = 3'd0; id_rs1 = 3'd0;
    push_exp("load_use_r0", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd1);
    step;
    clr();

    mem_ctrl = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      push_exp("mem_wait", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'(1 + i));
      step;
    end
    dmem_ready = 1'b1;
    push_exp("mem_done", 4'hF, 4'h0, 1'b1, 2'b00, 2'b00, 1'b0, 16'd5);
    step;
    clr();
    push_exp("post_mem", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd5);
    step;

    mem_ctrl = 4'b0010; dmem_ready = 1'b1;
    push_exp("zero_wait", 4'hF, 4'h0, 1'b1, 2'b00, 2'b00, 1'b0, 16'd5);
    step;
    clr();

    ex_branch_taken = 1'b1; ex_ctrl = 4'b1100; ex_rd = 3'd3; id_rs1 = 3'd3;
    push_exp("branch_over_lu", 4'hF, 4'b1100, 1'b0, 2'b00, 2'b00, 1'b0, 16'd5);
    step;
    clr();

    ex_branch_taken = 1'b1; mem_ctrl = 4'b0100;
    push_exp("freeze_over_branch", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'd5);
    step;
    ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    push_exp("load_done", 4'hF, 4'h0, 1'b1, 2'b00, 2'b00, 1'b0, 16'd6);
    step;
    clr();

    mem_ctrl = 4'b1000; mem_rd = 3'd5; wb_ctrl = 4'b1000; wb_rd = 3'd5;
    ex_rs1 = 3'd5; ex_rs2 = 3'd1;
    push_exp("fwd_mem", 4'hF, 4'h0, 1'b0, 2'b10, 2'b00, 1'b0, 16'd6);
    step;
    mem_ctrl = 4'b1100; dmem_ready = 1'b1;
    push_exp("fwd_load_wb", 4'hF, 4'h0, 1'b1, 2'b01, 2'b00, 1'b0, 16'd6);
    step;
    mem_ctrl = 4'b1000; dmem_ready = 1'b0; wb_rd = 3'd6; ex_rs1 = 3'd6; ex_rs2 = 3'd5;
    push_exp("fwd_b_mem_a_wb", 4'hF, 4'h0, 1'b0, 2'b01, 2'b10, 1'b0, 16'd6);
    step;
    mem_rd = 3'd0; wb_rd = 3'd0; ex_rs1 = 3'd0; ex_rs2 = 3'd0;
    push_exp("fwd_r0", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd6);
    step;
    clr();

    mem_ctrl = 4'b0010;
    push_exp("tmo_freeze", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'd6);
    step;
    for (int i = 1; i <= 15; i++) begin
      push_exp("tmo_wait", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'(6 + i));
      step;
    end
    push_exp("error", 4'h0, 4'h0, 1'b0, 2'b00, 2'b00, 1'b1, 16'd22);
    step;
    dmem_ready = 1'b1;
    push_exp("error_sticky", 4'h0, 4'h0, 1'b0, 2'b00, 2'b00, 1'b1, 16'd22);
    step;
    clr();

    reset_and_init();
    push_exp("run_after_err", 4'hF, 4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;
    mem_ctrl = 4'b0010;
    push_exp("wait2_freeze", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'd0);
    step;
    push_exp("wait2_hold", 4'h0, 4'h1, 1'b1, 2'b00, 2'b00, 1'b0, 16'd1);
    step;
    rst_n = 1'b0;
    push_exp("reset_mid_wait", 4'hF, 4'hF, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;
    rst_n = 1'b1;
    push_exp("init_after_mid", 4'hF, 4'hF, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0);
    step;

    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
